frequency_scheduler: RTL and testbench
======================================

# frequency_scheduler

Parametrised successor to the elevator's clock-divider block. It derives a slow, glitch-free divided clock `clk` and a one-cycle `tick` enable from `clk_50`, running only while the car is moving or a call is pending. It synchronises and latches N active-low call buttons into a pending-request mask that the controller clears per button once the call is served.

## Interface
- `CLK_FREQUENCY`, default 25_000_000: `clk_50` cycles per half-period of `clk`; must be ≥1.
- `BUTTONS`, default 3: number of call buttons; must be ≥1.
- `SYNC_STAGES`, default 2: synchroniser depth per button; must be ≥2.
- `RUN_HOLD`, default 2: extra `tick`s emitted after activity stops, before returning to idle.
- `clk_50`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `buttons`  in  BUTTONS  raw call buttons, active-low, asynchronous to `clk_50`.
- `moving`  in  1  car-in-motion flag, synchronous to `clk_50`.
- `clear`  in  BUTTONS  per-bit request clear, one-cycle pulse from the controller.
- `clk`  out  1  divided square wave, 50% duty, period 2·CLK_FREQUENCY cycles while running.
- `tick`  out  1  one-cycle pulse marking each rising edge of `clk`.
- `pending`  out  BUTTONS  latched request mask.
- `running`  out  1  high when the state is not IDLE.

## Operation
- Reset values:
  - Outputs `clk`, `tick`, `pending`, `running` = 0; state IDLE.
  - All synchroniser and edge-detect flops = 1 (button released), so releasing reset never produces a press.
  - Counters = 0.
- Button path, per bit:
  - SYNC_STAGES-flop synchroniser, then falling-edge detect (previous synced value 1, current 0).
  - A detected press sets `pending[i]`.
  - `clear[i]` resets `pending[i]`.
  - Press and clear in the same cycle: set wins.
  - A held button sets the bit once and does not re-set it after a clear until it has been released and pressed again.
- Activity `act` = `moving` | (OR of `pending`).
- State machine:
  - IDLE: divider counter held at 0, `clk` held at 0. If `act`, go to RUN and load counter 0.
  - RUN: divider runs. If !`act`, go to HOLD and load hold counter 0.
  - HOLD: divider keeps running; each `tick` increments the hold counter, saturating at RUN_HOLD. If `act`, go back to RUN with no divider disturbance. If hold counter ≥ RUN_HOLD on a falling toggle of `clk`, go to IDLE on that same edge.
- Divider, in RUN and HOLD:
  - Counter counts 0..CLK_FREQUENCY-1.
  - At terminal count, the next edge wraps the counter to 0 and toggles `clk`.
  - Counter width is max(1, clog2(CLK_FREQUENCY)). Hold counter width is clog2(RUN_HOLD+1).
- `tick` is a registered output, high exactly in the cycle after a 0→1 toggle of `clk`, i.e. the first cycle `clk` reads 1. It is never asserted in IDLE.
- Because IDLE is entered only on a falling toggle, `clk` never produces a runt pulse.
- Reset mid-operation: all outputs drop to their reset values immediately (asynchronously). `pending` is lost.

## Timing
- Button latency: `buttons[i]` first sampled low at edge k → `pending[i]` = 1 after edge k+SYNC_STAGES.
- Buttons must be held low ≥ SYNC_STAGES+1 `clk_50` cycles; shorter pulses may be missed. Debounce is done upstream.
- Clear latency: `clear[i]` high at edge k → `pending[i]` = 0 after edge k.
- Start-up:
  - `act` high at edge k → `running` = 1 after edge k.
  - First `clk` rise after edge k+CLK_FREQUENCY; first `tick` in the cycle that follows.
- `tick` period is 2·CLK_FREQUENCY cycles. With CLK_FREQUENCY=1, `clk` toggles every cycle and `tick` fires every 2 cycles.
- Shutdown: `running` falls on the first falling toggle of `clk` at which at least RUN_HOLD ticks have occurred in HOLD.

## Test plan
Bench parameters: CLK_FREQUENCY=10, BUTTONS=3, RUN_HOLD=2.
- Reset with all buttons high, `moving`=0 → `clk`, `tick`, `pending`, `running` all 0 for 100 cycles; no spurious `pending` on reset release.
- Hold `buttons[0]` low for 3 cycles → `pending`=3'b001 exactly 2 edges after first low sample; `running`=1 the next cycle; first `tick` 10 cycles later; ticks every 20 cycles.
- `moving`=1 with `pending`=0 → periodic ticks. Drop `moving` → exactly 2 further ticks, then `running`=0 on the following falling toggle, with `clk` ending at 0.
- In HOLD after 1 tick, press `buttons[1]` → returns to RUN with no phase slip (tick spacing stays 20); `pending`=3'b010.
- Press `buttons[2]` and pulse `clear[2]` in the same cycle the press is detected → `pending[2]` stays 1. Pulse `clear[2]` alone → `pending[2]`=0. Keep the button held → `pending[2]` stays 0.
- Assert `reset` mid-HOLD while `clk`=1 → `clk`, `tick`, `running`, `pending` = 0 immediately. After release with `act`=0, the block stays IDLE.

Source files
------------

// File: rtl/frequency_scheduler_if.sv
// Call-button / motion inputs and divided-clock / request outputs of the scheduler.
interface frequency_scheduler_if #(
    parameter int unsigned BUTTONS = 3
);
    logic [BUTTONS-1:0] buttons;
    logic               moving;
    logic [BUTTONS-1:0] clear;
    logic               clk;
    logic               tick;
    logic [BUTTONS-1:0] pending;
    logic               running;

    // Controller side: drives buttons/motion/clears, observes the scheduler.
    modport master (
        output buttons, moving, clear,
        input  clk, tick, pending, running
    );

    // Scheduler side.
    modport slave (
        input  buttons, moving, clear,
        output clk, tick, pending, running
    );
endinterface

// File: rtl/frequency_scheduler.sv
// Divided elevator clock with tick enable, gated by car motion and pending calls,
// plus synchronised, latched active-low call buttons.
module frequency_scheduler #(
    parameter int unsigned CLK_FREQUENCY = 25_000_000,
    parameter int unsigned BUTTONS       = 3,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned RUN_HOLD      = 2
) (
    input  logic                  clk_50,
    input  logic                  reset,
    frequency_scheduler_if.slave  bus
);

    localparam int unsigned CNT_W  = (CLK_FREQUENCY > 1) ? $clog2(CLK_FREQUENCY) : 1;
    localparam int unsigned HOLD_W = (RUN_HOLD > 0) ? $clog2(RUN_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_FREQUENCY - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RUN_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    logic [BUTTONS-1:0] r_sync [SYNC_STAGES];
    logic [BUTTONS-1:0] r_prev;
    logic [BUTTONS-1:0] r_pending;
    logic [BUTTONS-1:0] w_press;
    logic               w_act;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W-1:0]  w_hold_next;
    logic               r_clk;
    logic               w_clk_next;
    logic               r_tick;
    logic               w_tick_next;
    logic               r_running;
    logic               w_wrap;

    // Synchroniser chain and edge-detect history; reset to "released" so reset exit is never a press.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= '1;
            end
            r_prev <= '1;
        end else begin
            r_sync[0] <= bus.buttons;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_press = r_prev & ~r_sync[SYNC_STAGES-1];

    // Request latch: a detected press beats a same-cycle clear.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~bus.clear) | w_press;
        end
    end

    assign w_act  = bus.moving | (|r_pending);
    assign w_wrap = (r_cnt == CNT_LAST);

    // Next-state and divider logic; IDLE is only entered on a falling toggle so clk never runts.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hold_next  = r_hold;
        w_clk_next   = r_clk;
        w_tick_next  = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next  = '0;
                w_clk_next  = 1'b0;
                w_hold_next = '0;
                if (w_act) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_cnt_next  = w_wrap ? '0 : r_cnt + CNT_W'(1);
                w_clk_next  = r_clk ^ w_wrap;
                w_tick_next = w_wrap & ~r_clk;
                w_hold_next = '0;
                if (!w_act) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                w_cnt_next  = w_wrap ? '0 : r_cnt + CNT_W'(1);
                w_clk_next  = r_clk ^ w_wrap;
                w_tick_next = w_wrap & ~r_clk;
                if (w_act) begin
                    w_state_next = RUN;
                    w_hold_next  = '0;
                end else if (w_wrap && r_clk && (r_hold >= HOLD_MAX)) begin
                    w_state_next = IDLE;
                end else if (w_wrap && !r_clk && (r_hold < HOLD_MAX)) begin
                    w_hold_next = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
                w_clk_next   = 1'b0;
                w_hold_next  = '0;
            end
        endcase
    end

    // State, divider and output registers.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hold    <= '0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_hold    <= w_hold_next;
            r_clk     <= w_clk_next;
            r_tick    <= w_tick_next;
            r_running <= (w_state_next != IDLE);
        end
    end

    assign bus.clk     = r_clk;
    assign bus.tick    = r_tick;
    assign bus.pending = r_pending;
    assign bus.running = r_running;

endmodule

// File: tb/tb_frequency_scheduler.sv
// Bench for frequency_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_frequency_scheduler;

    localparam int unsigned CF = 10;
    localparam int unsigned NB = 3;
    localparam int unsigned SS = 2;
    localparam int unsigned RH = 2;

    logic clk_50;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   cyc_cnt;

    frequency_scheduler_if #(.BUTTONS(NB)) bus ();

    frequency_scheduler #(
        .CLK_FREQUENCY(CF),
        .BUTTONS      (NB),
        .SYNC_STAGES  (SS),
        .RUN_HOLD     (RH)
    ) dut (
        .clk_50(clk_50),
        .reset (reset),
        .bus   (bus)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc_cnt <= cyc_cnt + 1;

    logic [NB+2:0] w_obs;
    assign w_obs = {bus.clk, bus.tick, bus.running, bus.pending};

    // Behavioural model: time since start-up drives clk phase by division, samples kept as history.
    typedef struct packed {
        logic [NB-1:0]          pend;
        logic [SS+1:0][NB-1:0]  hist;
        logic                   run;
        logic                   hold;
        int                     t;
        int                     hcnt;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t mi, logic mv, logic [NB-1:0] btn, logic [NB-1:0] clr);
        model_t        mo;
        logic          act;
        logic          oc;
        logic          nc;
        logic [NB-1:0] press;
        mo  = mi;
        act = mv | (|mi.pend);
        if (!mi.run) begin
            if (act) begin
                mo.run  = 1'b1;
                mo.t    = 0;
                mo.hold = 1'b0;
            end
        end else begin
            oc   = ((mi.t / CF) % 2) == 1;
            nc   = (((mi.t + 1) / CF) % 2) == 1;
            mo.t = mi.t + 1;
            if (act) begin
                mo.hold = 1'b0;
            end else if (!mi.hold) begin
                mo.hold = 1'b1;
                mo.hcnt = 0;
            end else if (oc && !nc && mi.hcnt >= RH) begin
                mo.run  = 1'b0;
                mo.t    = 0;
                mo.hold = 1'b0;
            end else if (!oc && nc && mi.hcnt < RH) begin
                mo.hcnt = mi.hcnt + 1;
            end
        end
        mo.hist = {mi.hist[SS:0], btn};
        press   = mo.hist[SS+1] & ~mo.hist[SS];
        mo.pend = (mi.pend & ~clr) | press;
        return mo;
    endfunction

    function automatic logic [NB+2:0] model_out(model_t mm);
        logic c;
        logic tk;
        c  = mm.run && (((mm.t / CF) % 2) == 1);
        tk = mm.run && ((mm.t % (2 * CF)) == CF);
        return {c, tk, mm.run, mm.pend};
    endfunction

    // Model advances on the same edges as the design.
    always @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            m.pend <= '0;
            m.hist <= '1;
            m.run  <= 1'b0;
            m.hold <= 1'b0;
            m.t    <= 0;
            m.hcnt <= 0;
        end else begin
            m <= model_next(m, bus.moving, bus.buttons, bus.clear);
        end
    end

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_50);
            if (!bus.running) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_idle_timeout: running=%b required=0 within 300 cycles", name, bus.running);
        end
    endtask

    task automatic wait_tick(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk_50);
            if (bus.tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_tick_timeout: tick=%b required=1 within 60 cycles", name, bus.tick);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.buttons = '1;
        bus.moving  = 1'b0;
        bus.clear   = '0;
        repeat (3) @(negedge clk_50);
        n_checks++;
        if (w_obs !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%b required=%b", w_obs, 6'b0);
        end
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_50);
            n_checks++;
            if (w_obs !== '0) begin
                n_fail++;
                $display("FAIL reset_release c=%0d: outputs=%b required=%b", c, w_obs, 6'b0);
            end
        end
    endtask

    task automatic test_button_start();
        logic [NB+2:0] exp_v;
        logic          e_clk;
        logic          e_tick;
        @(negedge clk_50);
        bus.buttons[0] = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk_50);
            e_clk  = (c >= 13) && (((c - 13) % 20) < 10);
            e_tick = (c >= 13) && (((c - 13) % 20) == 0);
            exp_v  = {e_clk, e_tick, 1'(c >= 3), (c >= 2) ? 3'b001 : 3'b000};
            n_checks++;
            if (w_obs !== exp_v) begin
                n_fail++;
                $display("FAIL button_start c=%0d: outputs=%b required=%b", c, w_obs, exp_v);
            end
            n_checks++;
            if (w_obs !== model_out(m)) begin
                n_fail++;
                $display("FAIL button_start_model c=%0d: outputs=%b model=%b", c, w_obs, model_out(m));
            end
            if (c == 2) bus.buttons[0] = 1'b1;
        end
        bus.clear[0] = 1'b1;
        @(negedge clk_50);
        bus.clear[0] = 1'b0;
        wait_idle("button_start");
    endtask

    task automatic test_moving_shutdown();
        int   nt;
        bit   prev_clk;
        bit   ok;
        @(negedge clk_50);
        bus.moving = 1'b1;
        repeat ($urandom_range(1, 3)) wait_tick("moving");
        repeat ($urandom_range(1, 8)) @(negedge clk_50);
        bus.moving = 1'b0;
        nt       = 0;
        prev_clk = bus.clk;
        ok       = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_50);
            n_checks++;
            if (w_obs !== model_out(m)) begin
                n_fail++;
                $display("FAIL shutdown_model n=%0d: outputs=%b model=%b", n, w_obs, model_out(m));
            end
            if (bus.tick) nt++;
            if (!bus.running) begin
                ok = 1'b1;
                break;
            end
            prev_clk = bus.clk;
        end
        n_checks++;
        if (!ok || nt != int'(RH)) begin
            n_fail++;
            $display("FAIL shutdown_ticks: ticks=%0d stopped=%b required ticks=%0d stopped=1", nt, ok, RH);
        end
        n_checks++;
        if (bus.clk !== 1'b0 || prev_clk !== 1'b1) begin
            n_fail++;
            $display("FAIL shutdown_edge: clk=%b prev_clk=%b required clk=0 prev_clk=1", bus.clk, prev_clk);
        end
    endtask

    task automatic test_hold_rearm();
        int last;
        @(negedge clk_50);
        bus.moving = 1'b1;
        wait_tick("rearm_run");
        repeat ($urandom_range(1, 8)) @(negedge clk_50);
        bus.moving = 1'b0;
        wait_tick("rearm_hold");
        last = cyc_cnt;
        repeat ($urandom_range(1, 5)) @(negedge clk_50);
        bus.buttons[1] = 1'b0;
        repeat (3) @(negedge clk_50);
        bus.buttons[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_tick("rearm_spacing");
            n_checks++;
            if (cyc_cnt - last != int'(2 * CF)) begin
                n_fail++;
                $display("FAIL rearm_spacing k=%0d: spacing=%0d required=%0d", k, cyc_cnt - last, 2 * CF);
            end
            last = cyc_cnt;
        end
        n_checks++;
        if (bus.pending !== 3'b010 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_state: pending=%b running=%b required pending=010 running=1", bus.pending, bus.running);
        end
        bus.clear[1] = 1'b1;
        @(negedge clk_50);
        bus.clear[1] = 1'b0;
        wait_idle("rearm");
    endtask

    task automatic test_set_clear_race();
        @(negedge clk_50);
        bus.buttons[2] = 1'b0;
        repeat (2) @(negedge clk_50);
        bus.clear[2] = 1'b1;
        @(negedge clk_50);
        bus.clear[2] = 1'b0;
        n_checks++;
        if (bus.pending[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL race_set_wins: pending[2]=%b required=1", bus.pending[2]);
        end
        @(negedge clk_50);
        bus.clear[2] = 1'b1;
        @(negedge clk_50);
        bus.clear[2] = 1'b0;
        n_checks++;
        if (bus.pending[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL race_clear: pending[2]=%b required=0", bus.pending[2]);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_50);
            n_checks++;
            if (bus.pending[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL race_held c=%0d: pending[2]=%b required=0", c, bus.pending[2]);
            end
        end
        bus.buttons[2] = 1'b1;
        wait_idle("race");
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk_50);
        bus.moving = 1'b1;
        wait_tick("rst_run");
        repeat ($urandom_range(1, 8)) @(negedge clk_50);
        bus.moving = 1'b0;
        wait_tick("rst_hold");
        repeat ($urandom_range(0, 8)) @(negedge clk_50);
        n_checks++;
        if (bus.clk !== 1'b1 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_precondition: clk=%b running=%b required clk=1 running=1", bus.clk, bus.running);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== '0) begin
            n_fail++;
            $display("FAIL rst_async: outputs=%b required=%b", w_obs, 6'b0);
        end
        @(negedge clk_50);
        reset = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk_50);
            n_checks++;
            if (w_obs !== '0) begin
                n_fail++;
                $display("FAIL rst_stay_idle c=%0d: outputs=%b required=%b", c, w_obs, 6'b0);
            end
        end
    endtask

    task automatic test_random();
        int btn_left [NB];
        int mv_left;
        for (int i = 0; i < int'(NB); i++) btn_left[i] = $urandom_range(3, 40);
        mv_left = $urandom_range(20, 200);
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk_50);
            n_checks++;
            if (w_obs !== model_out(m)) begin
                n_fail++;
                $display("FAIL random c=%0d: outputs=%b model=%b", c, w_obs, model_out(m));
            end
            for (int i = 0; i < int'(NB); i++) begin
                btn_left[i]--;
                if (btn_left[i] <= 0) begin
                    bus.buttons[i] = ~bus.buttons[i];
                    btn_left[i]    = bus.buttons[i] ? $urandom_range(3, 80) : $urandom_range(3, 12);
                end
                bus.clear[i] = ($urandom_range(0, 15) == 0);
            end
            mv_left--;
            if (mv_left <= 0) begin
                bus.moving = ~bus.moving;
                mv_left    = $urandom_range(1, 120);
            end
        end
        bus.clear  = '0;
        bus.moving = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        cyc_cnt     = 0;
        reset       = 1'b1;
        bus.buttons = '1;
        bus.moving  = 1'b0;
        bus.clear   = '0;
        test_reset();
        test_button_start();
        test_moving_shutdown();
        test_hold_rearm();
        test_set_clear_race();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
